// File: rtl/register_multiport_pkg.sv
// Shared constants and types for the multiport integer register file.
package register_multiport_pkg;
    localparam int unsigned REG_XLEN  = 32;
    localparam int unsigned REG_NREGS = 32;
    localparam int unsigned REG_AW    = $clog2(REG_NREGS);

    typedef logic [REG_AW-1:0]   reg_addr_t;
    typedef logic [REG_XLEN-1:0] reg_data_t;
endpackage

// File: rtl/register_scoreboard.sv
// Per-register busy vector: writes clear, bset sets, set beats clear, x0 never busy.
module register_scoreboard
    import register_multiport_pkg::*;
#(
    parameter int unsigned NREGS  = REG_NREGS,
    parameter int unsigned NWRITE = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bset,
    input  logic [$clog2(NREGS)-1:0]      bset_addr,
    input  logic [NWRITE-1:0]             wren,
    input  logic [NWRITE*$clog2(NREGS)-1:0] waddr,
    output logic [NREGS-1:0]              busy
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] busy_q;

    // Clear on any write, then apply the set so a new producer wins the race.
    always_comb begin
        busy_d = busy_q;
        for (int j = 0; j < NWRITE; j++) begin
            if (wren[j]) begin
                busy_d[waddr[j*AW +: AW]] = 1'b0;
            end
        end
        if (bset) begin
            busy_d[bset_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy state register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
endmodule

// File: rtl/register_multiport.sv
// Multi-port register file with optional write-to-read bypass and busy scoreboard.
module register_multiport
    import register_multiport_pkg::*;
#(
    parameter int unsigned XLEN   = REG_XLEN,
    parameter int unsigned NREGS  = REG_NREGS,
    parameter int unsigned NREAD  = 2,
    parameter int unsigned NWRITE = 1,
    parameter int unsigned BYPASS = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NREAD-1:0]                rden,
    input  logic [NREAD*$clog2(NREGS)-1:0]  raddr,
    output logic [NREAD*XLEN-1:0]           rdata,
    output logic [NREAD-1:0]                rbusy,
    input  logic [NWRITE-1:0]               wren,
    input  logic [NWRITE*$clog2(NREGS)-1:0] waddr,
    input  logic [NWRITE*XLEN-1:0]          wdata,
    input  logic                            bset,
    input  logic [$clog2(NREGS)-1:0]        bset_addr
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NREGS-1:0][XLEN-1:0] regs_d;
    logic [NREGS-1:0][XLEN-1:0] regs_q;
    logic [NREGS-1:0]           busy;

    register_scoreboard #(
        .NREGS  (NREGS),
        .NWRITE (NWRITE)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .bset      (bset),
        .bset_addr (bset_addr),
        .wren      (wren),
        .waddr     (waddr),
        .busy      (busy)
    );

    // Ascending port order so the highest-index writer to an address wins.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NWRITE; j++) begin
            if (wren[j]) begin
                regs_d[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
            end
        end
        regs_d[0] = '0;
    end

    // Storage register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read muxes; outputs are forced to the cleared view while reset is asserted.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NREAD; i++) begin
            if (rst && rden[i] && (raddr[i*AW +: AW] != '0)) begin
                rdata[i*XLEN +: XLEN] = regs_q[raddr[i*AW +: AW]];
                rbusy[i]              = busy[raddr[i*AW +: AW]];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NWRITE; j++) begin
                        if (wren[j] && (waddr[j*AW +: AW] == raddr[i*AW +: AW])) begin
                            rdata[i*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
                            rbusy[i]              = 1'b0;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_register_multiport.sv
// Self-checking bench: a bypassing and a non-bypassing instance share stimulus.
module tb_register_multiport;
    import register_multiport_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  rden;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic [63:0] rdata_nb;
    logic [1:0]  rbusy_nb;
    logic [1:0]  wren;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        bset;
    reg_addr_t   bset_addr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic       rst;
        logic [1:0] rden;
        reg_addr_t  ra0;
        reg_addr_t  ra1;
        logic [1:0] wren;
        reg_addr_t  wa0;
        reg_data_t  wd0;
        reg_addr_t  wa1;
        reg_data_t  wd1;
        logic       bset;
        reg_addr_t  ba;
        reg_data_t  e_rd0;
        reg_data_t  e_rd1;
        logic [1:0] e_busy;
        reg_data_t  e_nb_rd0;
        logic       e_nb_busy0;
    } vec_t;

    typedef struct packed {
        reg_data_t  rd0;
        reg_data_t  rd1;
        logic [1:0] busy;
        reg_data_t  nb_rd0;
        logic       nb_busy0;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[16];

    register_multiport #(
        .XLEN   (32),
        .NREGS  (32),
        .NREAD  (2),
        .NWRITE (2),
        .BYPASS (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rden      (rden),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .wren      (wren),
        .waddr     (waddr),
        .wdata     (wdata),
        .bset      (bset),
        .bset_addr (bset_addr)
    );

    register_multiport #(
        .XLEN   (32),
        .NREGS  (32),
        .NREAD  (2),
        .NWRITE (2),
        .BYPASS (0)
    ) dut_nb (
        .clk       (clk),
        .rst       (rst),
        .rden      (rden),
        .raddr     (raddr),
        .rdata     (rdata_nb),
        .rbusy     (rbusy_nb),
        .wren      (wren),
        .waddr     (waddr),
        .wdata     (wdata),
        .bset      (bset),
        .bset_addr (bset_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string vn, input string what, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s got %h expected %h", vn, what, act, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, queue its expectation,
    // then compare the combinational outputs before the next rising edge.
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst       = v.rst;
        rden      = v.rden;
        raddr     = {v.ra1, v.ra0};
        wren      = v.wren;
        waddr     = {v.wa1, v.wa0};
        wdata     = {v.wd1, v.wd0};
        bset      = v.bset;
        bset_addr = v.ba;
        exp_q.push_back('{rd0: v.e_rd0, rd1: v.e_rd1, busy: v.e_busy,
                          nb_rd0: v.e_nb_rd0, nb_busy0: v.e_nb_busy0});
        #1;
        e = exp_q.pop_front();
        check(v.name, "rdata0", rdata[31:0], e.rd0);
        check(v.name, "rdata1", rdata[63:32], e.rd1);
        check(v.name, "rbusy", {30'd0, rbusy}, {30'd0, e.busy});
        check(v.name, "nb_rdata0", rdata_nb[31:0], e.nb_rd0);
        check(v.name, "nb_rbusy0", {31'd0, rbusy_nb[0]}, {31'd0, e.nb_busy0});
    endtask

    initial begin
        vec_t h;
        rst = 1'b0; rden = '0; raddr = '0; wren = '0; waddr = '0; wdata = '0;
        bset = 1'b0; bset_addr = '0;

        //          name          rst   rden   ra0    ra1    wren   wa0    wd0            wa1    wd1            bset  ba     e_rd0          e_rd1          busy   nb_rd0         nb_b
        vecs[0]  = '{"rst0",      1'b0, 2'b01, 5'd5,  5'd0,  2'b01, 5'd5,  32'h0000_DEAD, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         32'h0,         2'b00, 32'h0,         1'b0};
        vecs[1]  = '{"rst1",      1'b0, 2'b01, 5'd5,  5'd0,  2'b01, 5'd5,  32'h0000_DEAD, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         32'h0,         2'b00, 32'h0,         1'b0};
        vecs[2]  = '{"rst_rel",   1'b1, 2'b11, 5'd5,  5'd5,  2'b00, 5'd5,  32'h0000_DEAD, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         32'h0,         2'b00, 32'h0,         1'b0};
        vecs[3]  = '{"wr_x3",     1'b1, 2'b01, 5'd3,  5'd3,  2'b01, 5'd3,  32'h1234_5678, 5'd0,  32'h0,         1'b0, 5'd0,  32'h1234_5678, 32'h0,         2'b00, 32'h0,         1'b0};
        vecs[4]  = '{"rd_x3",     1'b1, 2'b11, 5'd3,  5'd3,  2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         1'b0, 5'd0,  32'h1234_5678, 32'h1234_5678, 2'b00, 32'h1234_5678, 1'b0};
        vecs[5]  = '{"rden1_off", 1'b1, 2'b01, 5'd3,  5'd3,  2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         1'b0, 5'd0,  32'h1234_5678, 32'h0,         2'b00, 32'h1234_5678, 1'b0};
        vecs[6]  = '{"x0_wr",     1'b1, 2'b11, 5'd0,  5'd0,  2'b01, 5'd0,  32'hFFFF_FFFF, 5'd0,  32'h0,         1'b1, 5'd0,  32'h0,         32'h0,         2'b00, 32'h0,         1'b0};
        vecs[7]  = '{"x0_next",   1'b1, 2'b11, 5'd0,  5'd0,  2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         32'h0,         2'b00, 32'h0,         1'b0};
        vecs[8]  = '{"prio_same", 1'b1, 2'b11, 5'd7,  5'd3,  2'b11, 5'd7,  32'h0000_000A, 5'd7,  32'h0000_000B, 1'b0, 5'd0,  32'h0000_000B, 32'h1234_5678, 2'b00, 32'h0,         1'b0};
        vecs[9]  = '{"prio_next", 1'b1, 2'b11, 5'd7,  5'd7,  2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         1'b0, 5'd0,  32'h0000_000B, 32'h0000_000B, 2'b00, 32'h0000_000B, 1'b0};
        vecs[10] = '{"bset_x9",   1'b1, 2'b01, 5'd9,  5'd0,  2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         1'b1, 5'd9,  32'h0,         32'h0,         2'b00, 32'h0,         1'b0};
        vecs[11] = '{"busy_x9",   1'b1, 2'b11, 5'd9,  5'd7,  2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         32'h0000_000B, 2'b01, 32'h0,         1'b1};
        vecs[12] = '{"wr_x9_byp", 1'b1, 2'b11, 5'd9,  5'd9,  2'b01, 5'd9,  32'h0000_0042, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0000_0042, 32'h0000_0042, 2'b00, 32'h0,         1'b1};
        vecs[13] = '{"x9_clear",  1'b1, 2'b11, 5'd9,  5'd9,  2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         1'b0, 5'd0,  32'h0000_0042, 32'h0000_0042, 2'b00, 32'h0000_0042, 1'b0};
        vecs[14] = '{"two_wr",    1'b1, 2'b11, 5'd10, 5'd11, 2'b11, 5'd10, 32'h0000_AAAA, 5'd11, 32'h0000_BBBB, 1'b0, 5'd0,  32'h0000_AAAA, 32'h0000_BBBB, 2'b00, 32'h0,         1'b0};
        vecs[15] = '{"two_rd",    1'b1, 2'b11, 5'd10, 5'd11, 2'b00, 5'd0,  32'h0,         5'd0,  32'h0,         1'b0, 5'd0,  32'h0000_AAAA, 32'h0000_BBBB, 2'b00, 32'h0000_AAAA, 1'b0};

        for (int k = 0; k < 16; k++) begin
            apply(vecs[k]);
        end

        // Set/clear race on x4, then a mid-run reset that must wipe data and busy bits.
        h = '{"race",      1'b1, 2'b01, 5'd4, 5'd0,  2'b01, 5'd4, 32'h0000_0099, 5'd0, 32'h0, 1'b1, 5'd4,
              32'h0000_0099, 32'h0,         2'b00, 32'h0,         1'b0};
        apply(h);
        h = '{"race_next", 1'b1, 2'b11, 5'd4, 5'd11, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0, 1'b0, 5'd0,
              32'h0000_0099, 32'h0000_BBBB, 2'b01, 32'h0000_0099, 1'b1};
        apply(h);
        h = '{"mid_rst",   1'b0, 2'b11, 5'd4, 5'd9,  2'b01, 5'd4, 32'h0000_0077, 5'd0, 32'h0, 1'b1, 5'd12,
              32'h0,         32'h0,         2'b00, 32'h0,         1'b0};
        apply(h);
        h = '{"post_rst4", 1'b1, 2'b11, 5'd4, 5'd12, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0, 1'b0, 5'd0,
              32'h0,         32'h0,         2'b00, 32'h0,         1'b0};
        apply(h);
        h = '{"post_rst",  1'b1, 2'b11, 5'd11, 5'd9, 2'b00, 5'd0, 32'h0,         5'd0, 32'h0, 1'b0, 5'd0,
              32'h0,         32'h0,         2'b00, 32'h0,         1'b0};
        apply(h);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
